// File: rtl/sipo_pkg.sv
// sipo_pkg: shared collector state encoding and count-width helper for sipo_deserializer
package sipo_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/sipo_out_buf.sv
// sipo_out_buf: single-entry valid/ready holding register that drops words arriving while full
module sipo_out_buf #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_err,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             err,
    output logic             overrun
);
    always_ff @(posedge clk) begin
        if (!resetn) begin
            data    <= '0;
            valid   <= 1'b0;
            err     <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= load && valid && !ready;
            if (load && (!valid || ready)) begin
                data  <= load_data;
                err   <= load_err;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: LSB-first serial-to-parallel receiver; define SIPO_PARITY_EN for a trailing even-parity bit
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  din,
    input  logic                  din_start,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  overrun,
    output logic                  parity_err
);
    localparam int CW = cnt_w(DATA_WIDTH);
    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [DATA_WIDTH-1:0] sr, sr_n;
    logic                  complete, perr;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sr    <= sr_n;
        end
    end
    // din_start always wins: it restarts the frame from any state, discarding partial bits
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        sr_n     = sr;
        complete = 1'b0;
        perr     = 1'b0;
        if (din_start) begin
            state_n = SHIFT;
            cnt_n   = CW'(1);
            sr_n    = DATA_WIDTH'(din);
        end else begin
            case (state)
                SHIFT: begin
                    sr_n  = sr | (DATA_WIDTH'(din) << cnt);
                    cnt_n = cnt + CW'(1);
                    if (cnt == CW'(DATA_WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
                        state_n = PARITY;
`else
                        state_n  = IDLE;
                        complete = 1'b1;
`endif
                    end
                end
`ifdef SIPO_PARITY_EN
                PARITY: begin
                    state_n  = IDLE;
                    complete = 1'b1;
                    perr     = ^sr ^ din;
                end
`endif
                default: ;
            endcase
        end
    end
    sipo_out_buf #(.WIDTH(DATA_WIDTH)) u_out_buf (
        .clk      (clk),
        .resetn   (resetn),
        .load     (complete),
        .load_data(sr_n),
        .load_err (perr),
        .ready    (dout_ready),
        .data     (dout),
        .valid    (dout_valid),
        .err      (parity_err),
        .overrun  (overrun)
    );
endmodule
